// File: rtl/mecobo_pkg.sv
// Shared definitions for the mecobo pin-controller bus: register offsets,
// collector state encoding and the bus address helper.
package mecobo_pkg;

  localparam logic [7:0] SAMPLE_REG = 8'd7;
  localparam logic [7:0] SAMPLE_CNT = 8'd8;
  localparam logic [7:0] STATUS_REG = 8'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    RD_CNT = 3'd2,
    RD_SMP = 3'd3,
    PUSH   = 3'd4
  } collector_state_t;

  // Pin controller address: {3'b0, pin index, register offset}.
  function automatic logic [18:0] pin_addr(input logic [7:0] pin, input logic [7:0] offset);
    return {3'b000, pin, offset};
  endfunction

endpackage

// File: rtl/sample_collector_if.sv
// Pin-controller read bus and sample record stream of the sample collector.
interface sample_collector_if;
  logic        bus_enable;
  logic        bus_rd;
  logic [18:0] bus_addr;
  logic [15:0] bus_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output bus_enable, bus_rd, bus_addr, out_valid, out_data,
    input  bus_rdata, out_ready
  );

  modport slave (
    input  bus_enable, bus_rd, bus_addr, out_valid, out_data,
    output bus_rdata, out_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy counter.
// A push while full is refused even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end
endmodule

// File: rtl/sample_collector.sv
// Polls pin controllers over the read bus and queues a record whenever a pin's
// sample counter changes. Define SAMPLE_COLLECTOR_DROP_CNT_EN to enable dropped_cnt.
module sample_collector
  import mecobo_pkg::*;
#(
  parameter int NUM_PINS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [NUM_PINS-1:0] pin_mask,
  sample_collector_if.master  sc,
  output logic                overflow,
  output logic [15:0]         dropped_cnt
);
  localparam int PW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam logic [PW-1:0] LAST_PIN = PW'(NUM_PINS - 1);

  collector_state_t state_r;
  collector_state_t after_pin_s;
  logic [PW-1:0]    pin_idx_r;
  logic [PW-1:0]    next_pin_s;
  logic             bus_enable_r;
  logic             bus_rd_r;
  logic [18:0]      bus_addr_r;
  logic [15:0]      cnt_r;
  logic             smp_r;
  logic [15:0]      last_cnt_r [NUM_PINS];
  logic             overflow_r;
  logic             push_s;
  logic [31:0]      record_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Pin advance target and where the FSM goes once the current pin is done.
  always_comb begin
    next_pin_s  = pin_idx_r + PW'(1);
    after_pin_s = IDLE;
    if (pin_idx_r == LAST_PIN) next_pin_s = PW'(0);
    else                       next_pin_s = pin_idx_r + PW'(1);
    if (run) after_pin_s = CHECK;
    else     after_pin_s = IDLE;
  end

  assign push_s   = (state_r == PUSH);
  assign record_s = {8'(pin_idx_r), 7'b0000000, smp_r, cnt_r};

  // Polling state machine with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pin_idx_r    <= PW'(0);
      bus_enable_r <= 1'b0;
      bus_rd_r     <= 1'b0;
      bus_addr_r   <= 19'h00000;
      cnt_r        <= 16'h0000;
      smp_r        <= 1'b0;
      overflow_r   <= 1'b0;
      for (int i = 0; i < NUM_PINS; i++) last_cnt_r[i] <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          bus_enable_r <= 1'b0;
          bus_rd_r     <= 1'b0;
          bus_addr_r   <= 19'h00000;
          state_r      <= run ? CHECK : IDLE;
        end
        CHECK: begin
          if (pin_mask[pin_idx_r]) begin
            bus_enable_r <= 1'b1;
            bus_rd_r     <= 1'b1;
            bus_addr_r   <= pin_addr(8'(pin_idx_r), SAMPLE_CNT);
            state_r      <= RD_CNT;
          end else begin
            pin_idx_r <= next_pin_s;
            state_r   <= after_pin_s;
          end
        end
        RD_CNT: begin
          cnt_r <= sc.bus_rdata;
          // Unchanged counter (including wrap back to an equal value) skips the pin.
          if (sc.bus_rdata == last_cnt_r[pin_idx_r]) begin
            bus_enable_r <= 1'b0;
            bus_rd_r     <= 1'b0;
            bus_addr_r   <= 19'h00000;
            pin_idx_r    <= next_pin_s;
            state_r      <= after_pin_s;
          end else begin
            bus_addr_r <= pin_addr(8'(pin_idx_r), SAMPLE_REG);
            state_r    <= RD_SMP;
          end
        end
        RD_SMP: begin
          smp_r                 <= sc.bus_rdata[0];
          last_cnt_r[pin_idx_r] <= cnt_r;
          bus_enable_r          <= 1'b0;
          bus_rd_r              <= 1'b0;
          bus_addr_r            <= 19'h00000;
          state_r               <= PUSH;
        end
        PUSH: begin
          if (fifo_full_s) overflow_r <= 1'b1;
          else             overflow_r <= overflow_r;
          pin_idx_r <= next_pin_s;
          state_r   <= after_pin_s;
        end
        default: begin
          bus_enable_r <= 1'b0;
          bus_rd_r     <= 1'b0;
          bus_addr_r   <= 19'h00000;
          state_r      <= IDLE;
        end
      endcase
    end
  end

`ifdef SAMPLE_COLLECTOR_DROP_CNT_EN
  logic [15:0] dropped_cnt_r;

  // Saturating count of records refused by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_cnt_r <= 16'h0000;
    end else if (push_s && fifo_full_s && (dropped_cnt_r != 16'hFFFF)) begin
      dropped_cnt_r <= dropped_cnt_r + 16'h0001;
    end
  end

  assign dropped_cnt = dropped_cnt_r;
`else
  assign dropped_cnt = 16'h0000;
`endif

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (~fifo_empty_s & sc.out_ready),
    .wdata (record_s),
    .rdata (sc.out_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign sc.bus_enable = bus_enable_r;
  assign sc.bus_rd     = bus_rd_r;
  assign sc.bus_addr   = bus_addr_r;
  assign sc.out_valid  = ~fifo_empty_s;
  assign overflow      = overflow_r;
endmodule

// File: doc/sample_collector.md
SAMPLE_COLLECTOR -- requirements
Module: sample_collector

Interface
REQ-001 SHALL have parameter NUM_PINS, default 8: number of pin controllers polled (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: sample record FIFO entries (power of 2).
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port run, input, 1: level; 1 = poll, 0 = stop after the current pin.
REQ-006 SHALL have port pin_mask, input, NUM_PINS: 1 = pin polled; sampled at each pin visit.
REQ-007 SHALL have port bus_enable, output, 1: bus select to pin controllers.
REQ-008 SHALL have port bus_rd, output, 1: read strobe.
REQ-009 SHALL have port bus_addr, output, 19: {3'b0, pin_idx[7:0], offset[7:0]}.
REQ-010 SHALL have port bus_rdata, input, 16: OR of all pin controller read data (combinational).
REQ-011 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-012 SHALL have port out_ready, input, 1: consumer pops head when out_valid & out_ready.
REQ-013 SHALL have port out_data, output, 32: {pin_idx[7:0], 7'b0, sample_bit, sample_cnt[15:0]}.
REQ-014 SHALL have port overflow, output, 1: sticky; record discarded because FIFO full.
REQ-015 SHALL have port dropped_cnt, output, 16: discarded-record count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, CHECK, RD_CNT, RD_SMP, PUSH; never write the bus (no write strobe).
REQ-017 IDLE: bus_enable=bus_rd=0; run=1 -> CHECK at current pin_idx.
REQ-018 CHECK: pin_mask[pin_idx]=0 -> advance pin_idx, stay CHECK (one cycle per skipped pin); else -> RD_CNT.
REQ-019 RD_CNT: drive bus_enable=bus_rd=1, offset 8 for exactly one cycle; capture bus_rdata into a register at that cycle's clock edge.
REQ-020 If captured count equals last_cnt[pin_idx] -> advance pin; else -> RD_SMP.
REQ-021 RD_SMP: one-cycle read at offset 7; capture bus_rdata[0] as sample_bit; last_cnt[pin_idx] <= captured count; -> PUSH.
REQ-022 PUSH: write record if FIFO not full, else set overflow and increment dropped_cnt; then advance pin.
REQ-023 Advance: pin_idx wraps NUM_PINS-1 -> 0; next state CHECK if run=1, else IDLE.
REQ-024 run deasserted mid-pin SHALL complete that pin (including PUSH) before IDLE.
REQ-025 Simultaneous FIFO push and pop when full SHALL count as full: record dropped.
REQ-026 Simultaneous push and pop when not full SHALL keep occupancy constant.
REQ-027 out_data SHALL be valid the cycle after the PUSH that wrote it (1-cycle latency to out_valid).
REQ-028 dropped_cnt SHALL saturate at 16'hFFFF.
REQ-029 last_cnt compare SHALL be 16-bit equality; counter wrap 16'hFFFF->0 counts as change.

Reset
REQ-030 Reset SHALL force IDLE, pin_idx=0, bus_enable=bus_rd=0, bus_addr=0, FIFO empty, out_valid=0, overflow=0, dropped_cnt=0, all last_cnt=0.
REQ-031 Reset mid-read SHALL deassert bus_rd on the next cycle and discard the in-flight record.

Configuration
REQ-032 SAMPLE_COLLECTOR_DROP_CNT_EN defined: dropped_cnt counts per REQ-022/028; undefined: dropped_cnt tied 0, counter logic absent, overflow unchanged.

Structure
REQ-033 Shared package mecobo_pkg SHALL hold pin register offsets (SAMPLE_REG=7, SAMPLE_CNT=8, STATUS_REG=9) and the state enumeration.
REQ-034 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; full/empty flags).

Verification
REQ-035 Pin 2 model cnt 0->1, sample 1, run=1, mask=8'h04 -> one record 32'h0201_0001; reads at 19'h0208 then 19'h0207.
REQ-036 Count unchanged over 3 polls -> only offset-8 reads, zero records.
REQ-037 Mask 8'h81, NUM_PINS=8 -> bus_addr pins visit 0,7,0,7; pins 1..6 never addressed.
REQ-038 FIFO_DEPTH=16, out_ready=0, 20 count changes -> 16 records, overflow=1, dropped_cnt=4 (0 without macro).
REQ-039 Reset asserted during RD_SMP -> next cycle bus_rd=0, out_valid=0, state IDLE.
REQ-040 run dropped during RD_CNT with changed count -> record pushed, then IDLE, pin_idx advanced.
